alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  32-bit integer ALU with a registered result; part of the datapath execute stage.
//  Selects one of eight operations on operands alua/alub via 3-bit aluop.
//  Inputs are sampled on every rising clk; the result appears on alur one cycle later.
//  One clock; reset is asynchronous and active-high.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (shift amount uses low log2(WIDTH) bits of alub)
// PORTS
//  clk     in   1      system clock, rising edge active
//  rst     in   1      asynchronous active-high reset
//  aluop   in   3      operation select (encoding below)
//  alua    in   WIDTH  operand A
//  alub    in   WIDTH  operand B
//  alur    out  WIDTH  registered result
//  zero    out  1      [ALU_FLAGS_EN only] registered: result == 0
//  carry   out  1      [ALU_FLAGS_EN only] registered: carry-out (ADD) / no-borrow (SUB)
//  ovf     out  1      [ALU_FLAGS_EN only] registered: signed overflow (ADD/SUB)
// BEHAVIOUR
//  - rst high (async): alur=0, and zero=1, carry=0, ovf=0; held until rst deasserts.
//  - Else, each rising clk: alur <= f(aluop, alua, alub). Latency 1 cycle, no stall,
//    no handshake; a new operation is accepted every cycle.
//  - Encoding (all results mod 2^WIDTH):
//    0 ADD  alua+alub
//    1 SUB  alua-alub (two's complement)
//    2 AND  alua&alub
//    3 OR   alua|alub
//    4 XOR  alua^alub
//    5 NOR  ~(alua|alub)
//    6 SLT  1 if $signed(alua)<$signed(alub), else 0 (zero-extended)
//    7 SLL  alua << alub[4:0]; upper bits of alub ignored
//  - ADD/SUB wrap silently; no exception or saturation.
//  - SLT with equal operands -> 0; 0x80000000 vs 0x7FFFFFFF -> 1.
//  - SLL by 0 -> alua unchanged; by 31 -> alua[0] in bit 31, rest 0.
//  - X/undefined aluop never occurs; all 8 codes are defined (case must be full).
//  - Reset deasserted mid-stream: first result is the op sampled at the first clk edge after release.
// CONFIGURATION
//  ALU_FLAGS_EN defined: zero/carry/ovf ports exist, registered in the same cycle as alur.
//   zero=(next alur==0) for every op; carry,ovf valid for ADD/SUB, forced 0 for ops 2-7.
//   ovf: ADD = A,B same sign and result sign differs; SUB = A,B signs differ and result sign != A.
//  ALU_FLAGS_EN undefined: flag ports and logic absent; alur behaviour identical.
// TESTING
//  1 rst=1 with arbitrary inputs -> alur=0 immediately (before any clk edge); zero=1 if flags.
//  2 aluop=0, A=0xFFFFFFFF, B=1 -> next cycle alur=0x00000000 (carry=1, zero=1, ovf=0).
//  3 aluop=1, A=0x80000000, B=1 -> alur=0x7FFFFFFF (ovf=1, carry=1).
//  4 aluop=2..5, A=0xF0F0F0F0, B=0xFF00FF00 -> 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F.
//  5 aluop=6: A=0xFFFFFFFF(-1), B=1 -> 1; A=5, B=5 -> 0.
//  6 aluop=7, A=1, B=0x0000003F -> alur=0x80000000 (only alub[4:0]=31 used); then sweep
//    aluop 0..7 with $random operands back-to-back, checking each result one cycle later.

Source files
------------

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- 32-bit integer ALU with a registered result (execute-stage datapath).
//
// One operation is accepted on every rising clk edge. Its result appears on
// alur one cycle later. There is no stall and no handshake.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined   -> zero/carry/ovf ports exist and are registered with alur.
//   undefined -> the flag ports and their logic are absent.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   aluop  in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLL
//   alua   in   WIDTH  operand A
//   alub   in   WIDTH  operand B (SLL uses only the low log2(WIDTH) bits)
//   alur   out  WIDTH  registered result
//   zero   out  1      [ALU_FLAGS_EN] result == 0
//   carry  out  1      [ALU_FLAGS_EN] carry-out (ADD) / no-borrow (SUB), else 0
//   ovf    out  1      [ALU_FLAGS_EN] signed overflow (ADD/SUB), else 0
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] alua,
  input  logic [WIDTH-1:0] alub,
  output logic [WIDTH-1:0] alur
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             ovf
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_SLL = 3'd7;

  // The adder/subtractor carry one extra bit only when the flags consume it.
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  assign sum_s  = {1'b0, alua} + {1'b0, alub};
  // Bit WIDTH of the difference is the borrow; carry reports its inverse.
  assign diff_s = {1'b0, alua} - {1'b0, alub};
`else
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  assign sum_s  = alua + alub;
  assign diff_s = alua - alub;
`endif

  logic             slt_s;
  logic [WIDTH-1:0] result_s;

  assign slt_s = ($signed(alua) < $signed(alub));

  // Next-result selection for all eight opcodes.
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (aluop)
      OP_ADD:  result_s = sum_s[WIDTH-1:0];
      OP_SUB:  result_s = diff_s[WIDTH-1:0];
      OP_AND:  result_s = alua & alub;
      OP_OR:   result_s = alua | alub;
      OP_XOR:  result_s = alua ^ alub;
      OP_NOR:  result_s = ~(alua | alub);
      OP_SLT:  result_s = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SLL:  result_s = alua << alub[SHW-1:0];
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic carry_s;
  logic ovf_s;

  // Carry and overflow are meaningful only for ADD/SUB and are forced low otherwise.
  always_comb begin
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (aluop)
      OP_ADD: begin
        carry_s = sum_s[WIDTH];
        // Same-sign operands whose sum flips sign.
        ovf_s   = (alua[WIDTH-1] == alub[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != alua[WIDTH-1]);
      end
      OP_SUB: begin
        carry_s = ~diff_s[WIDTH];
        // Opposite-sign operands whose difference takes B's sign.
        ovf_s   = (alua[WIDTH-1] != alub[WIDTH-1]) &&
                  (diff_s[WIDTH-1] != alua[WIDTH-1]);
      end
      default: begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end
`endif

  // Output register: result (and flags) captured every cycle; cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alur  <= {WIDTH{1'b0}};
`ifdef ALU_FLAGS_EN
      zero  <= 1'b1;
      carry <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      alur  <= result_s;
`ifdef ALU_FLAGS_EN
      zero  <= (result_s == {WIDTH{1'b0}});
      carry <= carry_s;
      ovf   <= ovf_s;
`endif
    end
  end

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- scoreboard bench for alu.
// Stimulus is driven on the falling edge and the expected response is pushed
// into a queue. A monitor pops one entry shortly after each rising edge and
// compares it with alur (and flags when ALU_FLAGS_EN is defined).
// -----------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [2:0]  aluop;
  logic [31:0] alua;
  logic [31:0] alub;
  logic [31:0] alur;
`ifdef ALU_FLAGS_EN
  logic        zero;
  logic        carry;
  logic        ovf;
`endif

  alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .aluop (aluop),
    .alua  (alua),
    .alub  (alub),
    .alur  (alur)
`ifdef ALU_FLAGS_EN
    ,
    .zero  (zero),
    .carry (carry),
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        c;
    logic        v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain wide integer arithmetic on the opcode definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string nm);
    exp_t   e;
    longint ua;
    longint ub;
    longint sa;
    longint sb;
    longint t;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.c = 1'b0;
    e.v = 1'b0;
    e.name = nm;
    case (op)
      3'd0: begin
        t   = ua + ub;
        e.r = t[31:0];
        e.c = (t > 64'sd4294967295);
        t   = sa + sb;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd1: begin
        t   = ua - ub;
        e.r = t[31:0];
        e.c = (ua >= ub);
        t   = sa - sb;
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~(a | b);
      3'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
      3'd7: begin
        t   = ua * (64'sd1 << (ub % 64'sd32));
        e.r = t[31:0];
      end
      default: e.r = 32'd0;
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string nm);
    aluop = op;
    alua  = a;
    alub  = b;
    q.push_back(model(op, a, b, nm));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: one result is due just after each rising edge following a push.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, alur, e.r);
`ifdef ALU_FLAGS_EN
      chk({e.name, ".zero"},  {31'd0, zero},  {31'd0, e.z});
      chk({e.name, ".carry"}, {31'd0, carry}, {31'd0, e.c});
      chk({e.name, ".ovf"},   {31'd0, ovf},   {31'd0, e.v});
`endif
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    chk(nm, alur, 32'd0);
`ifdef ALU_FLAGS_EN
    chk({nm, ".zero"},  {31'd0, zero},  32'd1);
    chk({nm, ".carry"}, {31'd0, carry}, 32'd0);
    chk({nm, ".ovf"},   {31'd0, ovf},   32'd0);
`endif
  endtask

  logic [31:0] ra;
  logic [31:0] rb;
  logic [2:0]  rop;

  initial begin
    rst   = 1'b0;
    aluop = 3'($urandom_range(0, 7));
    alua  = $urandom;
    alub  = $urandom;
    #1 rst = 1'b1;
    #1 chk_reset("reset_async");   // t=2, before the first rising edge
    repeat (2) @(negedge clk);
    chk_reset("reset_held");

    // Release reset; the first result is the op sampled at the next edge.
    @(negedge clk); rst = 1'b0;
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
    @(negedge clk); issue(3'd1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
    @(negedge clk); issue(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
    @(negedge clk); issue(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, "or");
    @(negedge clk); issue(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, "xor");
    @(negedge clk); issue(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, "nor");
    @(negedge clk); issue(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, "slt_neg");
    @(negedge clk); issue(3'd6, 32'h0000_0005, 32'h0000_0005, "slt_eq");
    @(negedge clk); issue(3'd6, 32'h8000_0000, 32'h7FFF_FFFF, "slt_min");
    @(negedge clk); issue(3'd7, 32'h0000_0001, 32'h0000_003F, "sll_mask");
    @(negedge clk); issue(3'd7, 32'hDEAD_BEEF, 32'h0000_0000, "sll_0");
    @(negedge clk); issue(3'd7, 32'h1234_5677, 32'h0000_001F, "sll_31");
    @(negedge clk); issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
    @(negedge clk); issue(3'd1, 32'h0000_0001, 32'h0000_0002, "sub_borrow");

    // Back-to-back opcode sweeps with random operands.
    for (int n = 0; n < 40; n++) begin
      for (int op = 0; op < 8; op++) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 7) == 0) rb = ra;
        @(negedge clk); issue(3'(op), ra, rb, "sweep");
      end
    end
    for (int n = 0; n < 200; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      @(negedge clk); issue(rop, ra, rb, "random");
    end
    drain();

    // Mid-stream reset between edges, then release with an op already set up.
    #2 rst = 1'b1;
    #1 chk_reset("reset_mid");
    @(negedge clk); chk_reset("reset_mid_held");
    rst = 1'b0;
    issue(3'd4, 32'hA5A5_A5A5, 32'h5A5A_5A5A, "after_reset");
    @(negedge clk); issue(3'd1, 32'h1234_5678, 32'h1234_5678, "sub_zero");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
